// File: rtl/i2s_transmit_24.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_transmit_24
// Purpose  : Philips I2S transmitter; serializes buffered stereo pairs onto sd_o
//            following an externally generated sck/ws.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_transmit_24 #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] right_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sd_o,
  output logic                  underflow_o,
  output logic                  active_o
);

  localparam int c_pad_bits = SLOT_WIDTH - DATA_WIDTH;

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sck_q;
  logic                  r_ws_q;
  logic [SLOT_WIDTH-1:0] r_shreg;
  logic [SLOT_WIDTH-1:0] w_shreg_nxt;
  logic [DATA_WIDTH-1:0] r_hold_left;
  logic [DATA_WIDTH-1:0] r_hold_right;
  logic [DATA_WIDTH-1:0] r_saved_right;
  logic [DATA_WIDTH-1:0] w_saved_right_nxt;
  logic                  r_hold_full;
  logic                  w_hold_full_nxt;
  logic                  w_sd_nxt;
  logic                  w_underflow_nxt;
  logic                  w_sck_fall;
  logic                  w_ws_chg;
  logic                  w_left_start;
  logic                  w_right_start;
  logic                  w_accept;

  function automatic logic [SLOT_WIDTH-1:0] f_word(input logic [DATA_WIDTH-1:0] s);
    return {s, {c_pad_bits{1'b0}}};
  endfunction

  assign w_sck_fall    = r_sck_q & ~sck_i;
  assign w_ws_chg      = w_sck_fall & (ws_i != r_ws_q);
  assign w_left_start  = w_ws_chg & ~ws_i;
  assign w_right_start = w_ws_chg & ws_i;
  assign w_accept      = valid_i & ready_o;
  assign active_o      = (r_state == RUN);

  always_comb begin
    w_state_nxt       = r_state;
    w_shreg_nxt       = r_shreg;
    w_saved_right_nxt = r_saved_right;
    w_hold_full_nxt   = r_hold_full;
    w_sd_nxt          = sd_o;
    w_underflow_nxt   = 1'b0;

    if (w_sck_fall) begin
      // The old MSB leaves before any reload, giving the one-SCK data delay after WS.
      w_sd_nxt = (r_state == RUN) ? r_shreg[SLOT_WIDTH-1] : 1'b0;
      if (r_state == RUN) begin
        w_shreg_nxt = r_shreg << 1;
      end
      if (w_left_start) begin
        w_state_nxt = RUN;
        if (r_hold_full) begin
          w_shreg_nxt       = f_word(r_hold_left);
          w_saved_right_nxt = r_hold_right;
          w_hold_full_nxt   = 1'b0;
        end else begin
          w_shreg_nxt       = '0;
          w_saved_right_nxt = '0;
          w_underflow_nxt   = 1'b1;
        end
      end else if (w_right_start && (r_state == RUN)) begin
        w_shreg_nxt = f_word(r_saved_right);
      end
    end

    // Accept needs an empty holding register, so it never collides with a consume.
    if (w_accept) begin
      w_hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state       <= SYNC;
      r_sck_q       <= 1'b0;
      r_ws_q        <= 1'b0;
      r_shreg       <= '0;
      r_hold_left   <= '0;
      r_hold_right  <= '0;
      r_saved_right <= '0;
      r_hold_full   <= 1'b0;
      ready_o       <= 1'b1;
      sd_o          <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sck_q       <= sck_i;
      if (w_sck_fall) begin
        r_ws_q <= ws_i;
      end
      if (w_accept) begin
        r_hold_left  <= left_i;
        r_hold_right <= right_i;
      end
      r_shreg       <= w_shreg_nxt;
      r_saved_right <= w_saved_right_nxt;
      r_hold_full   <= w_hold_full_nxt;
      ready_o       <= ~w_hold_full_nxt;
      sd_o          <= w_sd_nxt;
      underflow_o   <= w_underflow_nxt;
    end
  end

endmodule
`default_nettype wire
